poly_small_sqnorm: RTL and testbench

POLY_SMALL_SQNORM -- requirements
Module: poly_small_sqnorm

---
 rtl/poly_small_sqnorm.sv | 100 ++++++++++
 tb/tb_poly_small_sqnorm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/poly_small_sqnorm.sv
// Squared-norm checker for a freshly sampled (f,g) pair of small polynomials.
// Streams 2n signed coefficients and reports sum of squares, bound check and f parity.
module poly_small_sqnorm #(
    parameter int logn  = 9,
    parameter int f_bit = (logn == 9) ? 7 : 6,
    parameter int BOUND = 16823
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic signed [f_bit-1:0] in_data,
    output logic                    busy,
    output logic                    done,
    output logic [23:0]             sqnorm,
    output logic                    pass,
    output logic                    f_odd
);
    localparam int SQW = 2*f_bit - 1;

    typedef enum logic [2:0] {S_IDLE, S_ACC_F, S_ACC_G, S_FLUSH, S_DONE} state_t;

    // Handshake: a coefficient is taken on every rising edge where in_valid=1
    // while accumulating; there is no backpressure and other cycles ignore it.
    state_t                    state, state_next;
    logic [logn-1:0]           cnt;
    logic [SQW-1:0]            sq;
    logic                      sq_v;
    logic [23:0]               acc;
    logic                      parity;
    logic                      accept;
    logic                      last;
    logic signed [2*f_bit-1:0] prod;
    logic [23:0]               acc_sum;

    assign accept  = in_valid && (state == S_ACC_F || state == S_ACC_G);
    assign last    = accept && (&cnt);
    assign prod    = in_data * in_data;
    assign acc_sum = acc + 24'(sq);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_ACC_F;
            S_ACC_F: begin
                busy = 1'b1;
                if (last) state_next = S_ACC_G;
            end
            S_ACC_G: begin
                busy = 1'b1;
                if (last) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sq     <= '0;
            sq_v   <= 1'b0;
            acc    <= '0;
            parity <= 1'b0;
            pass   <= 1'b0;
        end else begin
            state <= state_next;
            sq_v  <= accept;
            sq    <= accept ? SQW'(prod) : '0;
            if (state == S_IDLE && start) begin
                acc    <= '0;
                cnt    <= '0;
                parity <= 1'b0;
                pass   <= 1'b0;
            end else begin
                if (sq_v) acc <= acc_sum;
                if (accept) begin
                    cnt <= cnt + logn'(1);
                    if (state == S_ACC_F) parity <= parity ^ in_data[0];
                end
                // FLUSH drains the last square, so acc_sum is the final norm here
                if (state == S_FLUSH) pass <= (acc_sum < 24'(BOUND));
            end
        end
    end

    assign sqnorm = acc;
    assign f_odd  = parity;

endmodule

// File: tb/tb_poly_small_sqnorm.sv
// Directed bench for poly_small_sqnorm: hand-computed norms, parity, bound edge,
// gapped input, mid-run reset and ignored start pulses.
module tb_poly_small_sqnorm;
    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic signed [6:0] in_data;
    logic              busy;
    logic              done;
    logic [23:0]       sqnorm;
    logic              pass;
    logic              f_odd;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic signed [6:0] fv [1024];

    poly_small_sqnorm dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .busy(busy), .done(done), .sqnorm(sqnorm), .pass(pass), .f_odd(f_odd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int fval, input int gval);
        for (int i = 0; i < 512; i++) fv[i] = 7'(fval);
        for (int i = 512; i < 1024; i++) fv[i] = 7'(gval);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_clear", 32'(sqnorm), 32'd0);
    endtask

    // One full measurement: start, 2n coefficients, then FLUSH/DONE/IDLE timing and result
    task automatic run(input string tag, input int maxgap, input bit extra_start,
                       input logic [31:0] exp_sq, input logic [31:0] exp_pass,
                       input logic [31:0] exp_odd);
        int gap;
        do_start();
        for (int i = 0; i < 1024; i++) begin
            gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = fv[i];
            if (extra_start && i == 100) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk({tag, "_flush_busy"}, 32'(busy), 32'd1);
        chk({tag, "_flush_done"}, 32'(done), 32'd0);
        @(negedge clk);
        if (extra_start) start = 1'b1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sqnorm"}, 32'(sqnorm), exp_sq);
        chk({tag, "_pass"}, 32'(pass), exp_pass);
        chk({tag, "_f_odd"}, 32'(f_odd), exp_odd);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_after_done"}, 32'(done), 32'd0);
        chk({tag, "_after_busy"}, 32'(busy), 32'd0);
        chk({tag, "_held"}, 32'(sqnorm), exp_sq);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sqnorm", 32'(sqnorm), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_f_odd", 32'(f_odd), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        fill(0, 0);
        run("zeros", 0, 1'b0, 32'd0, 32'd1, 32'd0);

        fill(1, 0);
        run("f_ones", 0, 1'b0, 32'd512, 32'd1, 32'd0);
        fv[0] = 7'sd2;
        run("f0_two", 0, 1'b1, 32'd515, 32'd1, 32'd1);

        fill(0, 0);
        fv[0] = -7'sd64; fv[1] = -7'sd64; fv[2] = -7'sd64; fv[3] = -7'sd64;
        fv[4] = 7'sd20;  fv[5] = 7'sd6;   fv[6] = 7'sd1;   fv[7] = 7'sd1;
        run("bound_in", 0, 1'b0, 32'd16822, 32'd1, 32'd0);
        fv[512] = 7'sd1;
        run("bound_out", 1, 1'b0, 32'd16823, 32'd0, 32'd0);

        // Strobes while idle must be dropped
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 7'sd5;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid_sqnorm", 32'(sqnorm), 32'd16823);
        chk("idle_valid_busy", 32'(busy), 32'd0);

        fill(-64, -64);
        run("max_gaps", 4, 1'b0, 32'd4194304, 32'd0, 32'd0);

        // Reset in the middle of f
        fill(1, 1);
        do_start();
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_data  = 7'sd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sqnorm", 32'(sqnorm), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        chk("midrst_idle_done", 32'(done), 32'd0);
        run("ones_after_rst", 0, 1'b0, 32'd1024, 32'd1, 32'd0);

        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
